ppu_run_dump_ctrl: RTL

Synthesizable run-control and result-dump sequencer for the pipelined ARM PPU. It watches the IF-stage instruction stream and detects program completion (a zero-instruction streak) or a cycle-budget timeout. It then freezes the pipeline, lets in-flight instructions drain, and streams a parametrised window of data memory out over a valid/ready port. It replaces ad-hoc end-of-program detection and memory printing with a reusable block usable on FPGA and in simulation.

---
 rtl/ppu_dbg_pkg.sv | 20 ++
 rtl/ppu_halt_detect.sv | 46 ++++
 rtl/ppu_run_dump_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ppu_dbg_pkg.sv
// Shared state encoding and address helpers for the PPU run-control / dump sequencer.
package ppu_dbg_pkg;

   typedef enum logic [2:0] {
      ST_RUN   = 3'd0,
      ST_DRAIN = 3'd1,
      ST_READ  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_SEND  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [31:0] HALT_INSTR = 32'h0;
   localparam int          WORD_BYTES = 4;

   function automatic logic [31:0] word_addr(input int base, input logic [31:0] idx);
      return 32'(base) + idx * 32'(WORD_BYTES);
   endfunction

endpackage

// File: rtl/ppu_halt_detect.sv
// Zero-instruction streak and saturating run-cycle counter; halt/timeout requests are
// combinational in the deciding cycle, no backpressure (counts only while run=1).
module ppu_halt_detect
   import ppu_dbg_pkg::*;
#(
   parameter int HALT_COUNT = 1,
   parameter int MAX_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [31:0] instruction,
   input  logic        stall,
   output logic        halt_req,
   output logic        timeout_req,
   output logic [31:0] cycle_count
);

   logic [31:0] streak;
   logic [31:0] streak_nxt;

   // A stalled fetch is the same instruction seen again, so it neither extends nor breaks the streak.
   always_comb begin
      streak_nxt = streak;
      if (!stall) begin
         streak_nxt = (instruction == HALT_INSTR) ? streak + 32'd1 : 32'd0;
      end
   end

   assign halt_req    = run && (streak_nxt >= 32'(HALT_COUNT));
   assign timeout_req = run && (cycle_count == 32'(MAX_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         streak      <= 32'd0;
         cycle_count <= 32'd0;
      end else if (run) begin
         streak <= streak_nxt;
         // The deciding cycle is not counted, so the count freezes at the exit value.
         if (!halt_req && !timeout_req && (cycle_count != '1)) begin
            cycle_count <= cycle_count + 32'd1;
         end
      end
   end

endmodule

// File: rtl/ppu_run_dump_ctrl.sv
// Detects program end or timeout, freezes and drains the pipeline, then dumps a memory window.
// One beat per 3 cycles (read, wait, send); a beat is held stable while dump_ready is low.
module ppu_run_dump_ctrl
   import ppu_dbg_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 32,
   parameter int DUMP_BASE    = 0,
   parameter int DUMP_WORDS   = 16,
   parameter int HALT_COUNT   = 1,
   parameter int DRAIN_CYCLES = 4,
   parameter int MAX_CYCLES   = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       instruction,
   input  logic              stall,
   output logic              halt_pipeline,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_last,
   output logic [31:0]       cycle_count,
   output logic              timeout,
   output logic              done
);

   localparam longint DUMP_END  = longint'(DUMP_BASE) + longint'(WORD_BYTES) * longint'(DUMP_WORDS);
   localparam longint ADDR_SPAN = longint'(1) << ADDR_W;

   if (DUMP_END > ADDR_SPAN) begin : g_bad_window
      $error("ppu_run_dump_ctrl: dump window exceeds the address space");
   end
   if ((DUMP_BASE % WORD_BYTES) != 0) begin : g_bad_base
      $error("ppu_run_dump_ctrl: DUMP_BASE must be word aligned");
   end
   if ((DUMP_WORDS < 1) || (HALT_COUNT < 1) || (MAX_CYCLES < 1)) begin : g_bad_count
      $error("ppu_run_dump_ctrl: DUMP_WORDS, HALT_COUNT and MAX_CYCLES must be at least 1");
   end

   state_t      state;
   logic [31:0] idx;
   logic [31:0] drain_cnt;
   logic        halt_req;
   logic        timeout_req;
   logic        last_word;

   ppu_halt_detect #(
      .HALT_COUNT(HALT_COUNT),
      .MAX_CYCLES(MAX_CYCLES)
   ) u_halt_detect (
      .clk        (clk),
      .reset      (reset),
      .run        (state == ST_RUN),
      .instruction(instruction),
      .stall      (stall),
      .halt_req   (halt_req),
      .timeout_req(timeout_req),
      .cycle_count(cycle_count)
   );

   assign last_word = (idx == 32'(DUMP_WORDS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_RUN;
         idx           <= 32'd0;
         drain_cnt     <= 32'd0;
         halt_pipeline <= 1'b0;
         mem_rd_en     <= 1'b0;
         mem_rd_addr   <= '0;
         dump_valid    <= 1'b0;
         dump_addr     <= '0;
         dump_data     <= '0;
         dump_last     <= 1'b0;
         timeout       <= 1'b0;
         done          <= 1'b0;
      end else begin
         mem_rd_en <= 1'b0;
         case (state)
            ST_RUN: begin
               if (halt_req || timeout_req) begin
                  state         <= ST_DRAIN;
                  halt_pipeline <= 1'b1;
                  timeout       <= !halt_req;
                  drain_cnt     <= 32'd0;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt + 32'd1 >= 32'(DRAIN_CYCLES)) begin
                  state       <= ST_READ;
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= ADDR_W'(word_addr(DUMP_BASE, idx));
               end else begin
                  drain_cnt <= drain_cnt + 32'd1;
               end
            end
            ST_READ: state <= ST_WAIT;
            ST_WAIT: begin
               state      <= ST_SEND;
               dump_valid <= 1'b1;
               dump_addr  <= mem_rd_addr;
               dump_data  <= mem_rd_data;
               dump_last  <= last_word;
            end
            ST_SEND: begin
               if (dump_ready) begin
                  dump_valid <= 1'b0;
                  dump_last  <= 1'b0;
                  if (last_word) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     idx         <= idx + 32'd1;
                     state       <= ST_READ;
                     mem_rd_en   <= 1'b1;
                     mem_rd_addr <= ADDR_W'(word_addr(DUMP_BASE, idx + 32'd1));
                  end
               end
            end
            ST_DONE: state <= ST_DONE;
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule
